// File: rtl/cmd_issue_scheduler_if.sv
// Command-issue bus: SPI-side command strobe in, system-controller latch handshake out.
// Carries no logic; master = command source / monitor, slave = scheduler.
// Backpressure is not signalled here; the scheduler reports fifo_full and overflow.
interface cmd_issue_scheduler_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   cmd_in;
    logic          cmd_in_valid;
    logic          busy;
    logic          flush;
    logic [31:0]   cmd_out;
    logic          latch_data;
    logic          cmd_issued;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          overflow;

    modport master (
        output cmd_in, cmd_in_valid, busy, flush,
        input  cmd_out, latch_data, cmd_issued, fifo_count, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  cmd_in, cmd_in_valid, busy, flush,
        output cmd_out, latch_data, cmd_issued, fifo_count, fifo_full, fifo_empty, overflow
    );
endinterface

// File: rtl/cmd_issue_scheduler.sv
// Buffers 32-bit commands and issues each one as a SETUP/LATCH/GAP strobe sequence.
// Latency: pop one cycle after push into an empty FIFO; latch_data rises one cycle later.
// Backpressure: none upstream; a word arriving while full (and not popping) is dropped and flags overflow.
module cmd_issue_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int LATCH_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    cmd_issue_scheduler_if.slave bus
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (LATCH_CYCLES > GAP_CYCLES) ? LATCH_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf_q;
    logic [31:0]   cmd_out_q;
    logic          latch_q;
    logic          issued_q;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);

    // busy only matters while idle; flush suppresses a pop in the same cycle
    assign pop  = (state == IDLE) && !empty && !bus.busy && !bus.flush;
    assign push = bus.cmd_in_valid && !bus.flush && (!full || pop);
    assign drop = bus.cmd_in_valid && !bus.flush && full && !pop;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.cmd_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    // cmd_out is loaded only on the IDLE->SETUP edge and held for the whole sequence
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            cmd_out_q <= '0;
            latch_q   <= 1'b0;
            issued_q  <= 1'b0;
        end else begin
            issued_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmd_out_q <= mem[rd_ptr];
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    state   <= LATCH;
                    latch_q <= 1'b1;
                    timer   <= '0;
                end
                LATCH: begin
                    if (timer == TW'(LATCH_CYCLES - 1)) begin
                        state    <= GAP;
                        latch_q  <= 1'b0;
                        issued_q <= 1'b1;
                        timer    <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    if (timer == TW'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_out    = cmd_out_q;
    assign bus.latch_data = latch_q;
    assign bus.cmd_issued = issued_q;
    assign bus.fifo_count = count;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_cmd_issue_scheduler.sv
// Bench for cmd_issue_scheduler: vector table, directed corner sequences, and random traffic
// compared every cycle against a queue-based model that tracks each issue by its age in cycles.
module tb_cmd_issue_scheduler;
    localparam int DEPTH   = 4;
    localparam int LAT     = 4;
    localparam int GAPC    = 4;
    localparam int SEQ_END = LAT + GAPC + 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    cmd_issue_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus();

    cmd_issue_scheduler #(
        .FIFO_DEPTH  (DEPTH),
        .LATCH_CYCLES(LAT),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: FIFO as a queue; an issue is described by edges elapsed since its pop.
    logic [31:0] m_q[$];
    logic [31:0] m_out = '0;
    logic        m_ovf = 1'b0;
    int          m_age = -1;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] dat;
        logic        bsy;
        logic        fl;
        logic [31:0] e_out;
        logic        e_lat;
        logic        e_iss;
        int          e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] seen[$];
    int          hi, iss, rises, low_run, min_low;
    logic        prev_lat;
    logic        rnd_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [31:0] dat,
                         input logic bsy, input logic fl);
        reset_n          = rst;
        bus.cmd_in_valid = vld;
        bus.cmd_in       = dat;
        bus.busy         = bsy;
        bus.flush        = fl;
    endtask

    task automatic model_update();
        bit idle, pop;
        if (!reset_n) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_age = -1;
            m_out = '0;
            return;
        end
        idle = (m_age < 0) || (m_age >= SEQ_END);
        pop  = idle && (m_q.size() > 0) && !bus.busy && !bus.flush;
        if (pop) m_age = 0;
        else if (!idle) m_age++;
        if (bus.flush) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) m_out = m_q.pop_front();
            if (bus.cmd_in_valid) begin
                if (m_q.size() < DEPTH) m_q.push_back(bus.cmd_in);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic model_check();
        chk("m_cmd_out",  bus.cmd_out,    m_out);
        chk("m_latch",    32'(bus.latch_data), 32'(m_age >= 1 && m_age <= LAT));
        chk("m_issued",   32'(bus.cmd_issued), 32'(m_age == LAT + 1));
        chk("m_count",    32'(bus.fifo_count), 32'(m_q.size()));
        chk("m_full",     32'(bus.fifo_full),  32'(m_q.size() == DEPTH));
        chk("m_empty",    32'(bus.fifo_empty), 32'(m_q.size() == 0));
        chk("m_overflow", 32'(bus.overflow),   32'(m_ovf));
    endtask

    task automatic step();
        model_update();
        @(posedge clock);
        #1;
        model_check();
    endtask

    task automatic wait_latch(input string name, input int budget);
        int n = 0;
        while (!bus.latch_data && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(bus.latch_data), 32'd1);
    endtask

    function automatic vec_t mkv(input logic rst, input logic vld, input logic [31:0] dat,
                                 input logic bsy, input logic fl, input logic [31:0] e_out,
                                 input logic e_lat, input logic e_iss, input int e_cnt,
                                 input logic e_ovf);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dat = dat; v.bsy = bsy; v.fl = fl;
        v.e_out = e_out; v.e_lat = e_lat; v.e_iss = e_iss; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // single push, busy low: pop at E1, latch E2..E5, issued after E6
        tbl.push_back(mkv(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0));
        tbl.push_back(mkv(1, 1, 32'hA5A5_0001, 0, 0, 32'h0,         0, 0, 1, 0));
        tbl.push_back(mkv(1, 0, 32'h0,         0, 0, 32'hA5A5_0001, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 32'h0,         0, 0, 32'hA5A5_0001, 1, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 32'h0,         0, 0, 32'hA5A5_0001, 1, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 32'h0,         0, 0, 32'hA5A5_0001, 1, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 32'h0,         0, 0, 32'hA5A5_0001, 1, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 32'h0,         0, 0, 32'hA5A5_0001, 0, 1, 0, 0));
        tbl.push_back(mkv(1, 0, 32'h0,         0, 0, 32'hA5A5_0001, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 32'h0,         0, 0, 32'hA5A5_0001, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].dat, tbl[i].bsy, tbl[i].fl);
            step();
            chk($sformatf("tbl%0d_cmd_out", i), bus.cmd_out, tbl[i].e_out);
            chk($sformatf("tbl%0d_latch", i),   32'(bus.latch_data), 32'(tbl[i].e_lat));
            chk($sformatf("tbl%0d_issued", i),  32'(bus.cmd_issued), 32'(tbl[i].e_iss));
            chk($sformatf("tbl%0d_count", i),   32'(bus.fifo_count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_empty", i),   32'(bus.fifo_empty), 32'(tbl[i].e_cnt == 0));
            chk($sformatf("tbl%0d_ovf", i),     32'(bus.overflow),   32'(tbl[i].e_ovf));
        end

        // six pushes while busy: four kept, overflow sticky, then issued in order
        drive(0, 0, 32'h0, 1, 0); step();
        for (int k = 1; k <= 6; k++) begin
            drive(1, 1, 32'(k), 1, 0);
            step();
        end
        drive(1, 0, 32'h0, 1, 0); step();
        chk("q36_count", 32'(bus.fifo_count), 32'd4);
        chk("q36_full",  32'(bus.fifo_full),  32'd1);
        chk("q36_ovf",   32'(bus.overflow),   32'd1);
        drive(1, 0, 32'h0, 0, 0);
        seen.delete();
        prev_lat = 1'b0; low_run = 0; min_low = 1000;
        for (int c = 0; c < 60; c++) begin
            step();
            if (bus.latch_data && !prev_lat) begin
                seen.push_back(bus.cmd_out);
                if (seen.size() > 1 && low_run < min_low) min_low = low_run;
            end
            if (bus.latch_data) low_run = 0;
            else low_run++;
            prev_lat = bus.latch_data;
        end
        chk("q36_n_issued", 32'(seen.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("q36_word%0d", k + 1), (k < seen.size()) ? seen[k] : 32'hDEAD_DEAD, 32'(k + 1));
        end
        chk("q36_min_gap", 32'(min_low >= GAPC), 32'd1);

        // busy rises during LATCH: current command completes, next waits for busy low
        drive(0, 0, 32'h0, 0, 0); step();
        drive(1, 1, 32'h1111_0037, 0, 0); step();
        drive(1, 1, 32'h2222_0037, 0, 0); step();
        drive(1, 0, 32'h0, 0, 0);
        wait_latch("q37_latch_seen", 10);
        drive(1, 0, 32'h0, 1, 0);
        hi = 1; iss = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            hi  += int'(bus.latch_data);
            iss += int'(bus.cmd_issued);
        end
        chk("q37_latch_cycles", 32'(hi),  32'(LAT));
        chk("q37_issued",       32'(iss), 32'd1);
        chk("q37_held_count",   32'(bus.fifo_count), 32'd1);
        chk("q37_held_out",     bus.cmd_out, 32'h1111_0037);
        drive(1, 0, 32'h0, 0, 0); step();
        chk("q37_next_pop",     bus.cmd_out, 32'h2222_0037);

        // push while full coincident with an IDLE pop
        drive(0, 0, 32'h0, 0, 0); step();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 32'h3800 + 32'(k), 1, 0);
            step();
        end
        drive(1, 1, 32'h0000_38FF, 0, 0); step();
        drive(1, 0, 32'h0, 1, 0);
        chk("q38_count", 32'(bus.fifo_count), 32'd4);
        chk("q38_ovf",   32'(bus.overflow),   32'd0);
        chk("q38_out",   bus.cmd_out,         32'h0000_3800);

        // flush during LATCH with three words queued
        drive(0, 0, 32'h0, 0, 0); step();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 32'h3900 + 32'(k), 0, 0);
            step();
        end
        chk("q39_pre_count", 32'(bus.fifo_count), 32'd3);
        chk("q39_pre_latch", 32'(bus.latch_data), 32'd1);
        drive(1, 0, 32'h0, 0, 1); step();
        drive(1, 0, 32'h0, 0, 0);
        chk("q39_count", 32'(bus.fifo_count), 32'd0);
        chk("q39_ovf",   32'(bus.overflow),   32'd0);
        chk("q39_latch", 32'(bus.latch_data), 32'd1);
        iss = 0; rises = 0; prev_lat = bus.latch_data;
        for (int c = 0; c < 30; c++) begin
            step();
            iss += int'(bus.cmd_issued);
            if (bus.latch_data && !prev_lat) rises++;
            prev_lat = bus.latch_data;
        end
        chk("q39_issued", 32'(iss),   32'd1);
        chk("q39_rises",  32'(rises), 32'd0);
        chk("q39_out",    bus.cmd_out, 32'h0000_3900);

        // reset in the second LATCH cycle
        drive(0, 0, 32'h0, 0, 0); step();
        drive(1, 1, 32'h0000_4000, 0, 0); step();
        drive(1, 1, 32'h0000_4001, 0, 0); step();
        drive(1, 0, 32'h0, 0, 0);
        wait_latch("q40_latch_seen", 10);
        step();
        chk("q40_latch_2nd", 32'(bus.latch_data), 32'd1);
        drive(0, 0, 32'h0, 0, 0); step();
        chk("q40_latch", 32'(bus.latch_data), 32'd0);
        chk("q40_out",   bus.cmd_out,         32'h0);
        chk("q40_count", 32'(bus.fifo_count), 32'd0);
        drive(1, 0, 32'h0, 0, 0);
        iss = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            iss += int'(bus.cmd_issued);
        end
        chk("q40_no_issue", 32'(iss), 32'd0);

        // random traffic against the model
        rnd_busy = 1'b0;
        drive(0, 0, 32'h0, 0, 0); step();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) rnd_busy = ~rnd_busy;
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 99) < 35, $urandom,
                  rnd_busy, $urandom_range(0, 39) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cmd_issue_scheduler.md
CMD_ISSUE_SCHEDULER -- requirements
Module: cmd_issue_scheduler

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, number of buffered 32-bit command words (power of 2, >=2).
REQ-002 The block SHALL have parameter LATCH_CYCLES, default 4, cycles latch_data is held high per command (>=3, clears the downstream 3-stage latch qualifier).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 4, minimum latch_data-low cycles between consecutive commands (>=1).
REQ-004 The block SHALL have one clock; reset is synchronous and active-low. Ports are listed below.
REQ-005 clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 cmd_in  in  32  command word from the SPI receiver.
REQ-008 cmd_in_valid  in  1  single-cycle strobe; cmd_in is valid when high.
REQ-009 busy  in  1  backend update cycle running (timer_enable); blocks new issue.
REQ-010 flush  in  1  synchronous clear of buffered commands and overflow.
REQ-011 cmd_out  out  32  command word presented to the system controller.
REQ-012 latch_data  out  1  latch strobe to the system controller.
REQ-013 cmd_issued  out  1  one-cycle pulse per completed issue.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
REQ-015 fifo_full / fifo_empty  out  1 each  fifo_count==FIFO_DEPTH / fifo_count==0.
REQ-016 overflow  out  1  sticky; a word was dropped.

Function
REQ-017 All outputs SHALL be registered; fifo_full/fifo_empty SHALL be derived from registered fifo_count.
REQ-018 A push SHALL occur when cmd_in_valid=1, flush=0, and (fifo_full=0 or a pop occurs in the same cycle); order is FIFO.
REQ-019 cmd_in_valid=1 with fifo_full=1 and no same-cycle pop SHALL drop the word and set overflow=1; fifo_count is unchanged.
REQ-020 Read/write pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-021 FSM states: IDLE, SETUP, LATCH, GAP.
REQ-022 IDLE: if fifo_empty=0 and busy=0, pop the head into cmd_out and go to SETUP; otherwise stay. cmd_out holds its last value.
REQ-023 SETUP: one cycle with latch_data=0 and cmd_out stable; then go to LATCH.
REQ-024 LATCH: latch_data=1 for exactly LATCH_CYCLES cycles; then go to GAP.
REQ-025 GAP: latch_data=0 for GAP_CYCLES cycles; cmd_issued=1 in the first GAP cycle only; then go to IDLE.
REQ-026 busy SHALL be sampled only in IDLE; a sequence already started SHALL complete even if busy rises.
REQ-027 cmd_out SHALL NOT change outside the IDLE->SETUP transition.
REQ-028 Timing: with a push at edge E0 into an empty FIFO and busy=0, fifo_count=1 after E0, the pop and SETUP occur at E1, latch_data is high after E2 through E(1+LATCH_CYCLES), and cmd_issued is high after E(2+LATCH_CYCLES).
REQ-029 Timing: the earliest next pop SHALL occur LATCH_CYCLES+GAP_CYCLES+2 cycles after the previous pop.
REQ-030 flush=1 SHALL zero the pointers, fifo_count and overflow next cycle, drop any same-cycle push without setting overflow, and not abort an in-flight SETUP/LATCH/GAP sequence.
REQ-031 flush=1 coincident with an IDLE pop SHALL suppress the pop; the FSM stays in IDLE.

Reset
REQ-032 reset_n=0 at a rising edge SHALL force: state IDLE, cmd_out=0, latch_data=0, cmd_issued=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0, and pointers=0.
REQ-033 Reset mid-sequence SHALL drop latch_data on the next edge; buffered words are lost.
REQ-034 Reset SHALL take priority over flush, push and pop.

Verification
REQ-035 Single push of 0xA5A5_0001, busy=0 -> cmd_out=0xA5A5_0001 after E1; latch_data high for 4 cycles from E2; one cmd_issued pulse after E6; fifo_empty=1.
REQ-036 Six back-to-back pushes with busy=1, FIFO_DEPTH=4 -> fifo_full=1, overflow=1, fifo_count=4; after busy=0, exactly words 1-4 are issued in order, each latch separated by >=4 low cycles.
REQ-037 busy rises during LATCH -> current command completes (4 high cycles, cmd_issued pulse); no next pop until busy=0 in IDLE.
REQ-038 Push with fifo_full=1 in the same cycle as an IDLE pop -> word accepted, fifo_count stays 4, overflow stays 0.
REQ-039 flush during LATCH with 3 words queued -> in-flight latch completes; fifo_count=0, overflow=0; no further issue.
REQ-040 reset_n=0 during the 2nd LATCH cycle -> latch_data=0, cmd_out=0, fifo_count=0 on the next edge; no cmd_issued pulse.
